// File: rtl/mad_stim_checker.sv
// Handshake-aware stimulus generator and in-order scoreboard for MAD units.
// Issues A=2i+3, B=2i+4, C=2i+5 and checks O against A*B+C.
module mad_stim_checker #(
    parameter int WIDTH      = 64,
    parameter int VECTORS    = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             START,
    input  logic             INTR_CLR,
    output logic             BUSY,
    output logic             INTR,
    output logic             IE,
    input  logic             IREADY,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    input  logic             OE,
    input  logic [WIDTH-1:0] O,
    output logic [15:0]      PASS_CNT,
    output logic [15:0]      FAIL_CNT,
    output logic             ERR_TIMEOUT,
    output logic             ERR_SPURIOUS
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [AW-1:0] P_ONE    = AW'(1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   NVEC     = 16'(VECTORS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [15:0]       idx;
    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [TW-1:0]     tmo_cnt;
    logic [WIDTH-1:0]  exp_val;
    logic full, empty, active, start_ok, accept, pop;
    logic spurious, tmo_hit, last_acc, done_entry;

    function automatic logic [WIDTH-1:0] vec(input logic [15:0] i,
                                             input logic [1:0]  k);
        logic [17:0] v;
        v = {1'b0, i, 1'b0} + {16'd0, k} + 18'd3;
        return WIDTH'(v);
    endfunction

    assign full     = (count == DEPTH_C);
    assign empty    = (count == CNT_ZERO);
    assign active   = (state == ISSUE) || (state == DRAIN);
    assign BUSY     = active;
    assign start_ok = START && ((state == IDLE) || (state == DONE));
    assign pop      = active && OE && !empty;
    assign spurious = active && OE && empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign IE       = (state == ISSUE) && (idx < NVEC) && (!full || OE);
    assign accept   = IE && IREADY;
    assign last_acc = accept && (idx == NVEC - 16'd1);
    assign tmo_hit  = active && !empty && !OE && (tmo_cnt == TMO_LAST);
    assign exp_val  = A * B + C;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (START) state_nx = ISSUE;
            ISSUE: begin
                if (tmo_hit)       state_nx = DONE;
                else if (last_acc) state_nx = DRAIN;
            end
            DRAIN: if (tmo_hit || empty) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign done_entry = (state_nx == DONE) && (state != DONE);

    always_ff @(posedge MCLK) begin
        if (active && accept) mem[wr_ptr] <= exp_val;
    end

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            INTR         <= 1'b0;
            A            <= '0;
            B            <= '0;
            C            <= '0;
            idx          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tmo_cnt      <= '0;
            PASS_CNT     <= '0;
            FAIL_CNT     <= '0;
            ERR_TIMEOUT  <= 1'b0;
            ERR_SPURIOUS <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                A            <= vec(16'd0, 2'd0);
                B            <= vec(16'd0, 2'd1);
                C            <= vec(16'd0, 2'd2);
                idx          <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                tmo_cnt      <= '0;
                PASS_CNT     <= '0;
                FAIL_CNT     <= '0;
                ERR_TIMEOUT  <= 1'b0;
                ERR_SPURIOUS <= 1'b0;
            end else if (active) begin
                if (accept) begin
                    wr_ptr <= wr_ptr + P_ONE;
                    idx    <= idx + 16'd1;
                    A      <= vec(idx + 16'd1, 2'd0);
                    B      <= vec(idx + 16'd1, 2'd1);
                    C      <= vec(idx + 16'd1, 2'd2);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + P_ONE;
                    if (mem[rd_ptr] == O) begin
                        if (PASS_CNT != 16'hFFFF) PASS_CNT <= PASS_CNT + 16'd1;
                    end else begin
                        if (FAIL_CNT != 16'hFFFF) FAIL_CNT <= FAIL_CNT + 16'd1;
                    end
                end
                if (spurious) ERR_SPURIOUS <= 1'b1;
                count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
                if (!empty && !OE) tmo_cnt <= tmo_cnt + T_ONE;
                else               tmo_cnt <= '0;
                // Abort discards whatever is still outstanding
                if (tmo_hit) begin
                    ERR_TIMEOUT <= 1'b1;
                    wr_ptr      <= '0;
                    rd_ptr      <= '0;
                    count       <= '0;
                    tmo_cnt     <= '0;
                end
            end
            if (done_entry)                INTR <= 1'b1;
            else if (INTR_CLR || start_ok) INTR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mad_stim_checker.sv
// Bench for mad_stim_checker: behavioural MAD pipeline plus result scoreboard.
// Each task runs one scenario and checks the checker's counters and flags.
module tb_mad_stim_checker;

    logic        MCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        START = 1'b0;
    logic        INTR_CLR = 1'b0;
    logic        BUSY, INTR, IE;
    logic        IREADY = 1'b1;
    logic [63:0] A, B, C;
    logic        OE;
    logic [63:0] O;
    logic [15:0] PASS_CNT, FAIL_CNT;
    logic        ERR_TIMEOUT, ERR_SPURIOUS;

    mad_stim_checker #(
        .WIDTH(64), .VECTORS(9), .FIFO_DEPTH(4), .TIMEOUT(20)
    ) dut (
        .MCLK(MCLK), .nRST(nRST), .START(START), .INTR_CLR(INTR_CLR),
        .BUSY(BUSY), .INTR(INTR), .IE(IE), .IREADY(IREADY),
        .A(A), .B(B), .C(C), .OE(OE), .O(O),
        .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT),
        .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_SPURIOUS(ERR_SPURIOUS)
    );

    always #5 MCLK = ~MCLK;

    // Behavioural MAD unit with programmable latency and faults
    logic        vp [16];
    logic [63:0] dp [16];
    int          lat = 3;
    int          stop_after = 1000;
    int          corrupt_idx = -1;
    int          out_cnt = 0;
    bit          spur_en = 0;
    bit          spur = 0;
    bit          model_clr = 0;
    logic        real_oe;

    assign real_oe = vp[lat-1] && (out_cnt < stop_after);
    assign OE = real_oe || spur;
    assign O  = (real_oe && out_cnt == corrupt_idx) ? dp[lat-1] + 64'd1
                                                    : dp[lat-1];

    always @(posedge MCLK) begin
        if (model_clr) begin
            for (int i = 0; i < 16; i++) vp[i] <= 1'b0;
            out_cnt <= 0;
            spur    <= 0;
        end else begin
            for (int i = 15; i > 0; i--) begin
                vp[i] <= vp[i-1];
                dp[i] <= dp[i-1];
            end
            vp[0] <= IE && IREADY;
            dp[0] <= A * B + C;
            if (real_oe) out_cnt <= out_cnt + 1;
            spur <= spur_en && real_oe && (out_cnt == 8);
        end
    end

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ph = 0;
    int          sb_idx, out_k, max_q, exp_pass, exp_fail;
    int          last_oe, end_cyc, start_cyc;
    bit          exp_spur, busy_s, toggle, chk_tbl, mid_start, prev_stall;
    logic [63:0] sbq [$];
    logic [191:0] held;
    logic [63:0] tbl [9] = '{17, 37, 65, 101, 145, 197, 257, 325, 401};

    function automatic logic [63:0] vecv(int i, int k);
        return 64'(2 * i + 3 + k);
    endfunction

    function automatic logic [63:0] exp_res(int i);
        return vecv(i, 0) * vecv(i, 1) + vecv(i, 2);
    endfunction

    task automatic cycle();
        logic [63:0] e;
        @(negedge MCLK);
        cyc++;
        busy_s = BUSY;
        if (busy_s) begin
            if (prev_stall) begin
                n_vec++;
                if ({A, B, C} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h want %h", {A, B, C}, held);
                end
            end
            prev_stall = IE && !IREADY;
            held = {A, B, C};
            if (OE) begin
                last_oe = cyc;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    if (O === e) exp_pass++;
                    else         exp_fail++;
                    if (chk_tbl) begin
                        n_vec++;
                        if (O !== tbl[out_k]) begin
                            n_fail++;
                            $display("FAIL result[%0d]: got %0d want %0d",
                                     out_k, O, tbl[out_k]);
                        end
                        out_k++;
                    end
                end else begin
                    exp_spur = 1;
                end
            end
            if (IE && IREADY) begin
                n_vec++;
                if ({A, B, C} !== {vecv(sb_idx, 0), vecv(sb_idx, 1), vecv(sb_idx, 2)}) begin
                    n_fail++;
                    $display("FAIL operands[%0d]: got %0d,%0d,%0d want %0d,%0d,%0d",
                             sb_idx, A, B, C, vecv(sb_idx, 0), vecv(sb_idx, 1),
                             vecv(sb_idx, 2));
                end
                sbq.push_back(exp_res(sb_idx));
                sb_idx++;
            end
            if (sbq.size() > max_q) max_q = sbq.size();
        end
        @(posedge MCLK);
        #1;
        ph = (ph + 1) % 4;
        IREADY = toggle ? (ph == 0 || ph == 3) : 1'b1;
        START = mid_start && (cyc == start_cyc + 4);
    endtask

    task automatic do_start();
        model_clr = 1;
        @(posedge MCLK);
        #1;
        model_clr = 0;
        sbq.delete();
        sb_idx = 0; out_k = 0; max_q = 0;
        exp_pass = 0; exp_fail = 0; exp_spur = 0;
        prev_stall = 0; last_oe = 0;
        ph = 0;
        IREADY = 1'b1;
        START = 1'b1;
        @(posedge MCLK);
        #1;
        START = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run(int bound);
        int n;
        n = 0;
        busy_s = 1;
        while (busy_s && n < bound) begin
            cycle();
            n++;
        end
        end_cyc = cyc;
        if (busy_s) begin
            n_vec++;
            n_fail++;
            $display("FAIL run_bound: BUSY still %0d after %0d cycles, want 0", BUSY, n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge MCLK);
        #1;
        n_vec++;
        if ({BUSY, INTR, IE, ERR_TIMEOUT, ERR_SPURIOUS} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {BUSY, INTR, IE, ERR_TIMEOUT, ERR_SPURIOUS});
        end
        n_vec++;
        if ({A, B, C} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_abc: got %0d,%0d,%0d want 0,0,0", A, B, C);
        end
        n_vec++;
        if ({PASS_CNT, FAIL_CNT} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", PASS_CNT, FAIL_CNT);
        end
        nRST = 1'b1;
        repeat (2) cycle();
        n_vec++;
        if (BUSY !== 1'b0 || PASS_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_oe_ignored: busy=%0d pass=%0d want 0/0", BUSY, PASS_CNT);
        end
    endtask

    task automatic test_ideal();
        lat = 3; toggle = 0; chk_tbl = 1;
        do_start();
        run(200);
        chk_tbl = 0;
        n_vec++;
        if (PASS_CNT !== 16'd9 || FAIL_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL ideal_cnt: got %0d/%0d want 9/0", PASS_CNT, FAIL_CNT);
        end
        n_vec++;
        if (INTR !== 1'b1 || sb_idx !== 9 || exp_pass !== 9) begin
            n_fail++;
            $display("FAIL ideal_done: intr=%0d issued=%0d good=%0d want 1/9/9",
                     INTR, sb_idx, exp_pass);
        end
        n_vec++;
        if (end_cyc - last_oe !== 2) begin
            n_fail++;
            $display("FAIL ideal_busy_fall: got %0d want 2", end_cyc - last_oe);
        end
        n_vec++;
        if ({ERR_TIMEOUT, ERR_SPURIOUS} !== 2'b00) begin
            n_fail++;
            $display("FAIL ideal_err: got %b want 00", {ERR_TIMEOUT, ERR_SPURIOUS});
        end
        INTR_CLR = 1'b1;
        @(posedge MCLK);
        #1;
        INTR_CLR = 1'b0;
        n_vec++;
        if (INTR !== 1'b0) begin
            n_fail++;
            $display("FAIL intr_clr: got %0d want 0", INTR);
        end
    endtask

    task automatic test_stall();
        lat = 3; toggle = 1; mid_start = 1;
        do_start();
        run(300);
        toggle = 0; mid_start = 0;
        n_vec++;
        if (PASS_CNT !== 16'd9 || FAIL_CNT !== 16'd0 || sb_idx !== 9) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d/%0d issued %0d want 9/0 issued 9",
                     PASS_CNT, FAIL_CNT, sb_idx);
        end
    endtask

    task automatic test_inflight();
        lat = 12;
        do_start();
        run(400);
        n_vec++;
        if (max_q !== 4) begin
            n_fail++;
            $display("FAIL inflight_max: got %0d want 4", max_q);
        end
        n_vec++;
        if (PASS_CNT !== 16'd9 || FAIL_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL inflight_cnt: got %0d/%0d want 9/0", PASS_CNT, FAIL_CNT);
        end
    endtask

    task automatic test_corrupt();
        lat = 3; corrupt_idx = 4;
        do_start();
        run(200);
        corrupt_idx = -1;
        n_vec++;
        if (PASS_CNT !== 16'd8 || FAIL_CNT !== 16'd1 || INTR !== 1'b1) begin
            n_fail++;
            $display("FAIL corrupt_cnt: got %0d/%0d intr %0d want 8/1 intr 1",
                     PASS_CNT, FAIL_CNT, INTR);
        end
        n_vec++;
        if (exp_fail !== 1) begin
            n_fail++;
            $display("FAIL corrupt_model: bad results %0d want 1", exp_fail);
        end
    endtask

    task automatic test_timeout();
        lat = 3; stop_after = 5;
        do_start();
        run(300);
        stop_after = 1000;
        n_vec++;
        if (ERR_TIMEOUT !== 1'b1 || PASS_CNT !== 16'd5 || INTR !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flags: tmo=%0d pass=%0d intr=%0d want 1/5/1",
                     ERR_TIMEOUT, PASS_CNT, INTR);
        end
        n_vec++;
        if (end_cyc - last_oe !== 21) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d want 21", end_cyc - last_oe);
        end
    endtask

    task automatic test_spurious_reset();
        lat = 3; spur_en = 1;
        do_start();
        run(200);
        spur_en = 0;
        n_vec++;
        if (ERR_SPURIOUS !== 1'b1 || exp_spur !== 1'b1 || PASS_CNT !== 16'd9) begin
            n_fail++;
            $display("FAIL spurious: err=%0d seen=%0d pass=%0d want 1/1/9",
                     ERR_SPURIOUS, exp_spur, PASS_CNT);
        end
        do_start();
        repeat (6) cycle();
        nRST = 1'b0;
        #1;
        n_vec++;
        if ({BUSY, INTR, IE, ERR_TIMEOUT, ERR_SPURIOUS} !== 5'b0 ||
            {A, B, C} !== 192'd0 || {PASS_CNT, FAIL_CNT} !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: flags %b pass %0d a %0d want 0",
                     {BUSY, INTR, IE, ERR_TIMEOUT, ERR_SPURIOUS}, PASS_CNT, A);
        end
        @(posedge MCLK);
        #1;
        nRST = 1'b1;
        repeat (15) cycle();
        n_vec++;
        if (PASS_CNT !== 16'd0 || ERR_SPURIOUS !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: pass=%0d spur=%0d busy=%0d want 0/0/0",
                     PASS_CNT, ERR_SPURIOUS, BUSY);
        end
        do_start();
        run(200);
        n_vec++;
        if (PASS_CNT !== 16'd9 || ERR_SPURIOUS !== 1'b0 || INTR !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: pass=%0d spur=%0d intr=%0d want 9/0/1",
                     PASS_CNT, ERR_SPURIOUS, INTR);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            vp[i] = 1'b0;
            dp[i] = '0;
        end
        toggle = 0; chk_tbl = 0; mid_start = 0;
        test_reset();
        test_ideal();
        test_stall();
        test_inflight();
        test_corrupt();
        test_timeout();
        test_spurious_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
